// File: rtl/bcd_game_pkg.sv
// Shared types, constants and digit helpers for the BCD addition game.
package bcd_game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    FINISH
  } game_state_t;

  localparam logic [3:0] MAX_SCORE     = 4'd10;
  localparam logic [7:0] SEED_FALLBACK = 8'h01;

  // Fold a raw nibble onto a displayable decimal digit: 10..15 become 4..9.
  function automatic logic [3:0] nibble_to_bcd(input logic [3:0] nibble);
    if (nibble > 4'd9) begin
      return nibble - 4'd6;
    end else begin
      return nibble;
    end
  endfunction

  // Units digit of the sum of two decimal digits, using a 5-bit intermediate.
  function automatic logic [3:0] digit_sum_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 5'd10) begin
      sum = sum - 5'd10;
    end
    return sum[3:0];
  endfunction

endpackage

// File: rtl/bcd_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR that supplies the digits for each round.
module bcd_lfsr8
  import bcd_game_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] SEED,
  output logic [7:0] VALUE
);

  logic feedback;

  assign feedback = VALUE[7] ^ VALUE[5] ^ VALUE[4] ^ VALUE[3];

  // Shift left every cycle; an all-zero seed would lock up, so it is replaced.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      VALUE <= (SEED == 8'h00) ? SEED_FALLBACK : SEED;
    end else begin
      VALUE <= {VALUE[6:0], feedback};
    end
  end

endmodule

// File: rtl/bcd_round_ctrl.sv
// Round controller for the BCD addition game: shows two digits, times the
// answer window, scores SUBMIT presses and counts rounds until the game ends.
module bcd_round_ctrl
  import bcd_game_pkg::*;
#(
  parameter int         ROUNDS       = 10,
  parameter int         ROUND_CYCLES = 500_000_000,
  parameter logic [7:0] SEED         = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       SUBMIT,
  input  logic [3:0] ANSWER,
  output logic [3:0] Q1,
  output logic [3:0] Q2,
  output logic [3:0] CORRECT,
  output logic       BUSY,
  output logic       DONE
);

  localparam int                 TIMER_W    = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ROUND_CYCLES - 1);
  localparam logic [3:0]         LAST_ROUND = 4'(ROUNDS - 1);

  game_state_t        state;
  logic [TIMER_W-1:0] timer;
  logic [3:0]         round_cnt;
  logic [7:0]         lfsr_value;

  logic start_r;
  logic start_d;
  logic start_armed;
  logic submit_r;
  logic submit_d;

  logic       start_edge;
  logic       submit_edge;
  logic       timer_expired;
  logic       round_end;
  logic       answer_ok;
  logic [3:0] expected_digit;
  logic [3:0] score_next;

  bcd_lfsr8 u_lfsr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .SEED  (SEED),
    .VALUE (lfsr_value)
  );

  // A START held through reset must be released before it can count, hence the arm flag.
  assign start_edge     = start_r & ~start_d & start_armed;
  assign submit_edge    = submit_r & ~submit_d;
  assign timer_expired  = (timer == TIMER_LAST);
  assign round_end      = submit_edge | timer_expired;
  assign expected_digit = digit_sum_mod10(Q1, Q2);
  assign answer_ok      = (ANSWER <= 4'd9) && (ANSWER == expected_digit);
  assign score_next     = (CORRECT >= MAX_SCORE) ? MAX_SCORE : CORRECT + 4'd1;

  // Register the buttons so each press yields exactly one single-cycle event.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      start_r     <= 1'b0;
      start_d     <= 1'b0;
      submit_r    <= 1'b0;
      submit_d    <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      start_r     <= START;
      start_d     <= start_r;
      submit_r    <= SUBMIT;
      submit_d    <= submit_r;
      start_armed <= start_armed | ~START;
    end
  end

  // Game sequencing: start, load digits, wait for an answer or timeout, finish.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      Q1        <= 4'd0;
      Q2        <= 4'd0;
      CORRECT   <= 4'd0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      timer     <= '0;
      round_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE, FINISH: begin
          if (start_edge) begin
            CORRECT   <= 4'd0;
            round_cnt <= 4'd0;
            BUSY      <= 1'b1;
            DONE      <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          Q1    <= nibble_to_bcd(lfsr_value[7:4]);
          Q2    <= nibble_to_bcd(lfsr_value[3:0]);
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          timer <= timer + TIMER_W'(1);
          if (round_end) begin
            if (submit_edge && answer_ok) begin
              CORRECT <= score_next;
            end
            if (round_cnt == LAST_ROUND) begin
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              state <= FINISH;
            end else begin
              round_cnt <= round_cnt + 4'd1;
              state     <= LOAD;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
